// File: rtl/smoke_heartbeat_if.sv
// Period-programming channel of the heartbeat generator: one valid/ready
// write of a period value into a selected tick channel.
interface smoke_heartbeat_if #(
  parameter int unsigned CH_W     = 2,
  parameter int unsigned PERIOD_W = 16
);
  logic                cfg_valid;
  logic                cfg_ready;
  logic [CH_W-1:0]     cfg_ch;
  logic [PERIOD_W-1:0] cfg_period;

  modport master (output cfg_valid, output cfg_ch, output cfg_period, input cfg_ready);
  modport slave  (input cfg_valid, input cfg_ch, input cfg_period, output cfg_ready);
endinterface

// File: rtl/smoke_heartbeat.sv
// Multi-channel heartbeat: per-channel periodic one-cycle ticks, beat counters
// with an optional budget, and a global enabled-cycle counter.
module smoke_heartbeat #(
  parameter int unsigned NUM_CH         = 4,
  parameter int unsigned PERIOD_W       = 16,
  parameter int unsigned CNT_W          = 32,
  parameter int unsigned DEFAULT_PERIOD = 16,
  parameter int unsigned MAX_BEATS      = 0
) (
  input  logic                    clock,
  input  logic                    reset_n,
  input  logic                    enable,
  smoke_heartbeat_if.slave        cfg,
  output logic [NUM_CH-1:0]       tick,
  output logic [NUM_CH*CNT_W-1:0] beat_count,
  output logic [CNT_W-1:0]        cycle_count,
  output logic [NUM_CH-1:0]       done,
  output logic                    all_done
);
  localparam int unsigned         CH_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam logic [PERIOD_W-1:0] RST_PERIOD = PERIOD_W'(DEFAULT_PERIOD);
  localparam logic [PERIOD_W-1:0] RST_PHASE  = (DEFAULT_PERIOD == 0) ? '0 : PERIOD_W'(DEFAULT_PERIOD - 1);
  localparam logic [CNT_W-1:0]    BUDGET     = CNT_W'(MAX_BEATS);

  typedef enum logic [1:0] {S_OFF, S_RUN, S_DONE} ch_state_e;
  localparam ch_state_e RST_STATE = (DEFAULT_PERIOD == 0) ? S_OFF : S_RUN;

  ch_state_e           state_q  [NUM_CH];
  ch_state_e           state_d  [NUM_CH];
  logic [PERIOD_W-1:0] period_q [NUM_CH];
  logic [PERIOD_W-1:0] period_d [NUM_CH];
  logic [PERIOD_W-1:0] phase_q  [NUM_CH];
  logic [PERIOD_W-1:0] phase_d  [NUM_CH];
  logic [CNT_W-1:0]    beat_q   [NUM_CH];
  logic [CNT_W-1:0]    beat_d   [NUM_CH];
  logic [NUM_CH-1:0]   tick_q, tick_d, hit, terminal;
  logic [CNT_W-1:0]    cycle_q, cycle_d;
  logic                ready_q, ready_d, all_done_q, all_done_d, accept;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == '1) ? v : v + CNT_W'(1);
  endfunction

  assign accept = cfg.cfg_valid & ready_q;

  // A config hit on a channel masks its terminal phase: config wins that edge.
  always_comb begin
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      hit[i]      = accept && (cfg.cfg_ch == CH_W'(i));
      terminal[i] = !hit[i] && (state_q[i] == S_RUN) && enable && (phase_q[i] == '0);
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      for (int unsigned i = 0; i < NUM_CH; i++) state_q[i] <= RST_STATE;
    end else begin
      for (int unsigned i = 0; i < NUM_CH; i++) state_q[i] <= state_d[i];
    end
  end

  always_comb begin
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      state_d[i] = state_q[i];
      if (hit[i]) begin
        state_d[i] = (cfg.cfg_period == '0) ? S_OFF : S_RUN;
      end else if (terminal[i] && (MAX_BEATS != 0) && (sat_inc(beat_q[i]) == BUDGET)) begin
        state_d[i] = S_DONE;
      end
    end
  end

  always_comb begin
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      period_d[i] = period_q[i];
      phase_d[i]  = phase_q[i];
      beat_d[i]   = beat_q[i];
      tick_d[i]   = 1'b0;
      if (hit[i]) begin
        period_d[i] = cfg.cfg_period;
        phase_d[i]  = (cfg.cfg_period == '0) ? '0 : cfg.cfg_period - PERIOD_W'(1);
        beat_d[i]   = '0;
      end else if (terminal[i]) begin
        tick_d[i]   = 1'b1;
        phase_d[i]  = period_q[i] - PERIOD_W'(1);
        beat_d[i]   = sat_inc(beat_q[i]);
      end else if ((state_q[i] == S_RUN) && enable) begin
        phase_d[i]  = phase_q[i] - PERIOD_W'(1);
      end
    end
    cycle_d    = enable ? sat_inc(cycle_q) : cycle_q;
    ready_d    = !accept;
    all_done_d = 1'b0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      if (state_q[i] != S_OFF) all_done_d = 1'b1;
    end
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      if (state_q[i] == S_RUN) all_done_d = 1'b0;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      for (int unsigned i = 0; i < NUM_CH; i++) begin
        period_q[i] <= RST_PERIOD;
        phase_q[i]  <= RST_PHASE;
        beat_q[i]   <= '0;
      end
      tick_q     <= '0;
      cycle_q    <= '0;
      ready_q    <= 1'b0;
      all_done_q <= 1'b0;
    end else begin
      for (int unsigned i = 0; i < NUM_CH; i++) begin
        period_q[i] <= period_d[i];
        phase_q[i]  <= phase_d[i];
        beat_q[i]   <= beat_d[i];
      end
      tick_q     <= tick_d;
      cycle_q    <= cycle_d;
      ready_q    <= ready_d;
      all_done_q <= all_done_d;
    end
  end

  always_comb begin
    for (int unsigned i = 0; i < NUM_CH; i++) done[i] = (state_q[i] == S_DONE);
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_beat
    assign beat_count[g*CNT_W +: CNT_W] = beat_q[g];
  end

  assign tick          = tick_q;
  assign cycle_count   = cycle_q;
  assign all_done      = all_done_q;
  assign cfg.cfg_ready = ready_q;
endmodule

// File: tb/tb_smoke_heartbeat.sv
// Bench for smoke_heartbeat: two instances (unlimited budget / budget of 2),
// directed sequences plus random traffic checked against a beat-arithmetic model.
module tb_smoke_heartbeat;
  logic         clock = 1'b0;
  logic         reset_n = 1'b0;
  logic         enable = 1'b0;
  logic [3:0]   tick_a, done_a;
  logic [127:0] beat_a;
  logic [31:0]  cyc_a;
  logic         alld_a;
  logic [2:0]   tick_b, done_b;
  logic [95:0]  beat_b;
  logic [31:0]  cyc_b;
  logic         alld_b;
  int           n_total = 0;
  int           n_bad = 0;

  smoke_heartbeat_if #(.CH_W(2), .PERIOD_W(16)) if_a ();
  smoke_heartbeat_if #(.CH_W(2), .PERIOD_W(16)) if_b ();

  smoke_heartbeat #(.NUM_CH(4), .PERIOD_W(16), .CNT_W(32), .DEFAULT_PERIOD(16), .MAX_BEATS(0)) dut (
    .clock(clock), .reset_n(reset_n), .enable(enable), .cfg(if_a.slave), .tick(tick_a),
    .beat_count(beat_a), .cycle_count(cyc_a), .done(done_a), .all_done(alld_a));

  smoke_heartbeat #(.NUM_CH(3), .PERIOD_W(16), .CNT_W(32), .DEFAULT_PERIOD(4), .MAX_BEATS(2)) dut_b (
    .clock(clock), .reset_n(reset_n), .enable(enable), .cfg(if_b.slave), .tick(tick_b),
    .beat_count(beat_b), .cycle_count(cyc_b), .done(done_b), .all_done(alld_b));

  always #5 clock = ~clock;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d want %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference model: a channel ticks whenever its count of enabled running
  // edges since (re)load is a multiple of its period; beats = count / period.
  function automatic int nch(input int d);  return (d == 0) ? 4 : 3;  endfunction
  function automatic int defp(input int d); return (d == 0) ? 16 : 4; endfunction
  function automatic int maxb(input int d); return (d == 0) ? 0 : 2;  endfunction

  longint m_per [2][4];
  longint m_k   [2][4];
  bit [3:0] m_tick [2];
  longint m_cyc [2];
  bit m_ready [2];
  bit m_alld  [2];
  bit mdl_on = 1'b0;

  function automatic longint m_beats(input int d, input int c);
    if (m_per[d][c] == 0) return 0;
    return m_k[d][c] / m_per[d][c];
  endfunction

  function automatic bit m_done(input int d, input int c);
    return (maxb(d) != 0) && (m_per[d][c] != 0) && (m_beats(d, c) >= maxb(d));
  endfunction

  task automatic m_step(input int d, input bit v, input int ch, input int p);
    bit acc, any_on, all_ok;
    if (!reset_n) begin
      for (int c = 0; c < 4; c++) begin
        m_per[d][c] = defp(d);
        m_k[d][c]   = 0;
      end
      m_tick[d] = '0; m_cyc[d] = 0; m_ready[d] = 1'b0; m_alld[d] = 1'b0;
      return;
    end
    any_on = 1'b0; all_ok = 1'b1;
    for (int c = 0; c < nch(d); c++) begin
      if (m_per[d][c] != 0) begin
        any_on = 1'b1;
        if (!m_done(d, c)) all_ok = 1'b0;
      end
    end
    acc = v && m_ready[d];
    m_tick[d] = '0;
    for (int c = 0; c < nch(d); c++) begin
      if (acc && ch == c) begin
        m_per[d][c] = p;
        m_k[d][c]   = 0;
      end else if (enable && m_per[d][c] != 0 && !m_done(d, c)) begin
        m_k[d][c]++;
        if (m_k[d][c] % m_per[d][c] == 0) m_tick[d][c] = 1'b1;
      end
    end
    if (enable && m_cyc[d] < 64'hFFFF_FFFF) m_cyc[d]++;
    m_ready[d] = !acc;
    m_alld[d]  = any_on && all_ok;
  endtask

  always @(posedge clock) begin
    m_step(0, if_a.cfg_valid, int'(if_a.cfg_ch), int'(if_a.cfg_period));
    m_step(1, if_b.cfg_valid, int'(if_b.cfg_ch), int'(if_b.cfg_period));
    if (!reset_n) mdl_on = 1'b1;
  end

  always @(negedge clock) begin
    if (mdl_on) begin
      bit [3:0] md;
      for (int d = 0; d < 2; d++) begin
        md = '0;
        for (int c = 0; c < nch(d); c++) md[c] = m_done(d, c);
        if (d == 0) begin
          chk("mdl_tick_a", 64'(tick_a), 64'(m_tick[0]));
          chk("mdl_done_a", 64'(done_a), 64'(md));
          chk("mdl_cyc_a", 64'(cyc_a), 64'(m_cyc[0]));
          chk("mdl_alld_a", 64'(alld_a), 64'(m_alld[0]));
          chk("mdl_ready_a", 64'(if_a.cfg_ready), 64'(m_ready[0]));
          for (int c = 0; c < 4; c++) chk($sformatf("mdl_beat_a%0d", c), 64'(beat_a[c*32 +: 32]), 64'(m_beats(0, c)));
        end else begin
          chk("mdl_tick_b", 64'(tick_b), 64'(m_tick[1]));
          chk("mdl_done_b", 64'(done_b), 64'(md));
          chk("mdl_cyc_b", 64'(cyc_b), 64'(m_cyc[1]));
          chk("mdl_alld_b", 64'(alld_b), 64'(m_alld[1]));
          chk("mdl_ready_b", 64'(if_b.cfg_ready), 64'(m_ready[1]));
          for (int c = 0; c < 3; c++) chk($sformatf("mdl_beat_b%0d", c), 64'(beat_b[c*32 +: 32]), 64'(m_beats(1, c)));
        end
      end
    end
  end

  task automatic drive_a(input bit v, input int ch, input int p);
    if_a.cfg_valid = v; if_a.cfg_ch = 2'(ch); if_a.cfg_period = 16'(p);
  endtask

  task automatic drive_b(input bit v, input int ch, input int p);
    if_b.cfg_valid = v; if_b.cfg_ch = 2'(ch); if_b.cfg_period = 16'(p);
  endtask

  task automatic smp();
    @(negedge clock);
  endtask

  task automatic nxt();
    @(posedge clock);
    #1;
  endtask

  // One reset edge; returns positioned at the start of cycle 0.
  task automatic do_reset();
    reset_n = 1'b0;
    drive_a(1'b0, 0, 0);
    drive_b(1'b0, 0, 0);
    smp();
    nxt();
    reset_n = 1'b1;
  endtask

  task automatic chk_reset_a(input string pfx);
    chk({pfx, "_tick"}, 64'(tick_a), 64'(0));
    chk({pfx, "_cyc"}, 64'(cyc_a), 64'(0));
    chk({pfx, "_ready"}, 64'(if_a.cfg_ready), 64'(0));
    chk({pfx, "_done"}, 64'(done_a), 64'(0));
    chk({pfx, "_alld"}, 64'(alld_a), 64'(0));
    chk({pfx, "_beats"}, 64'(beat_a), 64'(0));
  endtask

  typedef struct {
    bit         en;
    bit         v;
    int         ch;
    int         p;
    logic [3:0] exp_tick;
    bit         exp_ready;
  } vec_t;

  vec_t tbl [17];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 17; i++) tbl[i] = '{en: 1'b1, v: 1'b0, ch: 0, p: 0, exp_tick: 4'b0000, exp_ready: 1'b1};
    tbl[0].exp_ready = 1'b0;
    tbl[5].v = 1'b1; tbl[5].ch = 1; tbl[5].p = 3;
    tbl[6].exp_ready = 1'b0;
    tbl[7].v = 1'b1; tbl[7].ch = 2; tbl[7].p = 0;
    tbl[8].exp_ready = 1'b0;
    tbl[9].exp_tick = 4'b0010; tbl[12].exp_tick = 4'b0010; tbl[15].exp_tick = 4'b0010;
    tbl[16].exp_tick = 4'b1001;

    drive_a(1'b0, 0, 0);
    drive_b(1'b0, 0, 0);

    // Default periods on dut; budget/all_done and a config/terminal collision on dut_b.
    do_reset();
    for (int c = 0; c <= 48; c++) begin
      enable = 1'b1;
      if (c == 1)      drive_b(1'b1, 1, 0);
      else if (c == 3) drive_b(1'b1, 2, 0);
      else             drive_b(1'b0, 0, 0);
      smp();
      if (c == 0) begin
        chk_reset_a("rst_a");
        chk("rst_b_ready", 64'(if_b.cfg_ready), 64'(0));
        chk("rst_b_tick", 64'(tick_b), 64'(0));
      end
      if (c == 2)  chk("b_ready_after_acc", 64'(if_b.cfg_ready), 64'(0));
      if (c == 4)  chk("b_tick4", 64'(tick_b), 64'(3'b001));
      if (c == 8) begin
        chk("b_tick8", 64'(tick_b), 64'(3'b001));
        chk("b_done8", 64'(done_b), 64'(3'b001));
        chk("b_beat8", 64'(beat_b[31:0]), 64'(2));
        chk("b_alld8", 64'(alld_b), 64'(0));
      end
      if (c == 9)  chk("b_alld9", 64'(alld_b), 64'(1));
      if (c == 12) chk("b_tick12", 64'(tick_b), 64'(0));
      if (c == 16 || c == 32 || c == 48) chk($sformatf("a_tick%0d", c), 64'(tick_a), 64'(4'hF));
      if (c == 17) chk("a_tick17", 64'(tick_a), 64'(0));
      if (c == 48) begin
        for (int k = 0; k < 4; k++) chk($sformatf("a_beat48_%0d", k), 64'(beat_a[k*32 +: 32]), 64'(3));
        chk("a_cyc48", 64'(cyc_a), 64'(48));
      end
      nxt();
    end
    drive_b(1'b0, 0, 0);

    do_reset();
    for (int i = 0; i < 17; i++) begin
      enable = tbl[i].en;
      drive_a(tbl[i].v, tbl[i].ch, tbl[i].p);
      smp();
      chk($sformatf("tbl%0d_tick", i), 64'(tick_a), 64'(tbl[i].exp_tick));
      chk($sformatf("tbl%0d_ready", i), 64'(if_a.cfg_ready), 64'(tbl[i].exp_ready));
      nxt();
    end
    drive_a(1'b0, 0, 0);

    // ch0 period 8 accepted at end of cycle 1; enable low in cycles 12..21;
    // reprogram ch0 on its terminal-phase edge in cycle 35.
    do_reset();
    for (int c = 0; c <= 45; c++) begin
      enable = !(c >= 12 && c <= 21);
      if (c == 0 || c == 1) drive_a(1'b1, 0, 8);
      else if (c == 35)     drive_a(1'b1, 0, 5);
      else                  drive_a(1'b0, 0, 0);
      smp();
      if (c == 10) begin
        chk("frz_tick10", 64'(tick_a), 64'(4'b0001));
        chk("frz_beat10", 64'(beat_a[31:0]), 64'(1));
      end
      if (c == 12 || c == 17 || c == 22) chk($sformatf("frz_cyc%0d", c), 64'(cyc_a), 64'(12));
      if (c == 23) chk("frz_cyc23", 64'(cyc_a), 64'(13));
      if (c == 16 || c == 18) chk($sformatf("frz_tick%0d", c), 64'(tick_a), 64'(0));
      if (c == 26) chk("frz_tick26", 64'(tick_a), 64'(4'b1110));
      if (c == 28) begin
        chk("frz_tick28", 64'(tick_a), 64'(4'b0001));
        chk("frz_beat28", 64'(beat_a[31:0]), 64'(2));
      end
      if (c == 36) begin
        chk("col_tick36", 64'(tick_a), 64'(0));
        chk("col_beat36", 64'(beat_a[31:0]), 64'(0));
        chk("col_ready36", 64'(if_a.cfg_ready), 64'(0));
      end
      if (c == 41) begin
        chk("col_tick41", 64'(tick_a), 64'(4'b0001));
        chk("col_beat41", 64'(beat_a[31:0]), 64'(1));
      end
      nxt();
    end
    drive_a(1'b0, 0, 0);

    // One-cycle reset mid-run with a config request pending on the same edge.
    do_reset();
    enable = 1'b1;
    for (int c = 0; c < 115; c++) begin
      smp();
      nxt();
    end
    reset_n = 1'b0;
    drive_a(1'b1, 0, 3);
    smp();
    chk("mid_beat7", 64'(beat_a[31:0]), 64'(7));
    nxt();
    reset_n = 1'b1;
    drive_a(1'b0, 0, 0);
    smp();
    chk_reset_a("mid_rst");
    nxt();
    for (int c = 1; c <= 16; c++) begin
      smp();
      if (c == 16) begin
        chk("mid_tick16", 64'(tick_a), 64'(4'hF));
        chk("mid_beat16", 64'(beat_a[31:0]), 64'(1));
      end
      nxt();
    end

    // Random traffic, including out-of-range channel 3 on dut_b.
    for (int i = 0; i < 3000; i++) begin
      reset_n = ($urandom_range(0, 199) != 0);
      enable  = ($urandom_range(0, 9) != 0);
      drive_a($urandom_range(0, 5) == 0, int'($urandom_range(0, 3)),
              ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 40)) : int'($urandom_range(0, 6)));
      drive_b($urandom_range(0, 4) == 0, int'($urandom_range(0, 3)),
              ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 40)) : int'($urandom_range(0, 6)));
      smp();
      nxt();
    end
    reset_n = 1'b1;
    drive_a(1'b0, 0, 0);
    drive_b(1'b0, 0, 0);
    smp();

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end
endmodule
